// File: rtl/gnt_window_if.sv
// Grant-window bus between the arbiter (master side) and the consuming DUT
// plus its requesters (slave side).
interface gnt_window_if #(
  parameter int NREQ = 2
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic            hold;
  logic            gnt;
  logic [OW-1:0]   gnt_owner;
  logic            gnt_done;
  logic [NREQ-1:0] starve;

  modport master (
    input  req,
    input  hold,
    output gnt,
    output gnt_owner,
    output gnt_done,
    output starve
  );

  modport slave (
    output req,
    output hold,
    input  gnt,
    input  gnt_owner,
    input  gnt_done,
    input  starve
  );
endinterface

// File: rtl/gnt_window_arb.sv
// Round-robin grant source issuing fixed-length grant windows separated by a
// minimum gap, with sticky per-requester starvation watchdogs.
module gnt_window_arb #(
  parameter int NREQ    = 2,
  parameter int GNT_LEN = 8,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  gnt_window_if.master bus
);
  localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXLEN = (GNT_LEN > GAP) ? GNT_LEN : GAP;
  localparam int CW     = $clog2(MAXLEN + 1);
  localparam int SW     = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LEN_LAST = CW'(GNT_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [SW-1:0] TO_VAL   = SW'(TIMEOUT);
  localparam logic [OW-1:0] OWN_MAX  = OW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            gnt_q, gnt_d;
  logic            done_q, done_d;
  logic [SW-1:0]   scnt_q [NREQ];
  logic [SW-1:0]   scnt_d [NREQ];
  logic [NREQ-1:0] starve_q, starve_d;

  logic            decision;
  logic            grant_ok;
  logic            pick_found;
  logic [OW-1:0]   pick;
  int              pick_idx;

  // Round-robin search: first requesting index at or after the pointer, wrapping.
  always_comb begin
    pick       = ptr_q;
    pick_found = 1'b0;
    pick_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pick_idx = int'(ptr_q) + k;
      if (pick_idx >= NREQ) pick_idx = pick_idx - NREQ;
      if (!pick_found && bus.req[pick_idx]) begin
        pick_found = 1'b1;
        pick       = OW'(pick_idx);
      end
    end
  end

  // Decision cycles are every IDLE cycle and the final GAP cycle; hold only matters here.
  assign decision = (state_q == S_IDLE) || ((state_q == S_GAP) && (cnt_q == GAP_LAST));
  assign grant_ok = decision && pick_found && !bus.hold;

  // Window sequencing: a started window always runs its full length, then the gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_GRANT: begin
        if (cnt_q == LEN_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (grant_ok) begin
      state_d = S_GRANT;
      cnt_d   = '0;
      owner_d = pick;
      ptr_d   = (pick == OWN_MAX) ? '0 : pick + 1'b1;
    end
    gnt_d  = (state_d == S_GRANT);
    done_d = (state_d == S_GRANT) && (cnt_d == LEN_LAST);
  end

  // Starvation watchdogs: count waiting cycles, pause while owning the window, latch at TIMEOUT.
  always_comb begin
    starve_d = starve_q;
    for (int i = 0; i < NREQ; i++) begin
      scnt_d[i] = scnt_q[i];
      if (!bus.req[i] || (grant_ok && (pick == OW'(i)))) begin
        scnt_d[i] = '0;
      end else if (!((state_q == S_GRANT) && (owner_q == OW'(i))) && (scnt_q[i] != TO_VAL)) begin
        scnt_d[i] = scnt_q[i] + 1'b1;
      end
      if (scnt_d[i] == TO_VAL) starve_d[i] = 1'b1;
    end
  end

  // State and registered outputs; synchronous active-low reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= 1'b0;
      done_q   <= 1'b0;
      starve_q <= '0;
      for (int i = 0; i < NREQ; i++) scnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      starve_q <= starve_d;
      for (int i = 0; i < NREQ; i++) scnt_q[i] <= scnt_d[i];
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_owner = owner_q;
  assign bus.gnt_done  = done_q;
  assign bus.starve    = starve_q;
endmodule
